// File: rtl/gpu_dither_modulate.sv
// Purpose: rasterizer colour back-end. Applies PSX texel modulation, adds the
//          4x4 ordered-dither offset, saturates to 0..255 and emits 5:5:5 colour.
// Latency: 2 cycles from input acceptance to o_valid, 1 pixel/cycle throughput.
// Backpressure: full valid/ready. The pipeline holds up to 2 pixels. o_ready is
//               combinational from i_ready and is forced low by i_clear.
//
// Ports:
//   clk, i_nrst        clock, asynchronous active-low reset
//   i_clear            synchronous flush of both pipeline stages
//   i_valid / o_ready  input handshake
//   i_posX, i_posY     screen coordinate LSBs that select the dither cell
//   i_r/g/b            8-bit vertex colour
//   i_texR/G/B         5-bit texel colour
//   i_texEn            modulate the vertex colour by the texel colour
//   i_ditherEn         apply the dither offset
//   i_tag              opaque sideband that travels with the pixel
//   o_valid / i_ready  output handshake
//   o_r/g/b, o_tag     5-bit colour and its sideband
module gpu_dither_modulate #(
  parameter int TAGW = 16
) (
  input  logic            clk,
  input  logic            i_nrst,
  input  logic            i_clear,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_posX,
  input  logic [1:0]      i_posY,
  input  logic [7:0]      i_r,
  input  logic [7:0]      i_g,
  input  logic [7:0]      i_b,
  input  logic [4:0]      i_texR,
  input  logic [4:0]      i_texG,
  input  logic [4:0]      i_texB,
  input  logic            i_texEn,
  input  logic            i_ditherEn,
  input  logic [TAGW-1:0] i_tag,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [4:0]      o_r,
  output logic [4:0]      o_g,
  output logic [4:0]      o_b,
  output logic [TAGW-1:0] o_tag
);

  // Texel modulation: (col * tex) >> 4. A texel value of 16 is unity gain,
  // so the result can exceed 255 (up to 494) and needs 9 bits.
  function automatic logic [8:0] modulate(input logic [7:0] col,
                                          input logic [4:0] tex,
                                          input logic       en);
    logic [12:0] prod;
    prod = 13'(col) * 13'(tex);
    return en ? 9'(prod >> 4) : {1'b0, col};
  endfunction

  // 4x4 ordered-dither matrix, indexed by {row, column}.
  function automatic logic signed [11:0] dither_off(input logic [1:0] y,
                                                    input logic [1:0] x);
    logic signed [11:0] d;
    case ({y, x})
      4'h0: d = -12'sd4;
      4'h1: d =  12'sd0;
      4'h2: d = -12'sd3;
      4'h3: d =  12'sd1;
      4'h4: d =  12'sd2;
      4'h5: d = -12'sd2;
      4'h6: d =  12'sd3;
      4'h7: d = -12'sd1;
      4'h8: d = -12'sd3;
      4'h9: d =  12'sd1;
      4'hA: d = -12'sd4;
      4'hB: d =  12'sd0;
      4'hC: d =  12'sd3;
      4'hD: d = -12'sd1;
      4'hE: d =  12'sd2;
      default: d = -12'sd2;
    endcase
    return d;
  endfunction

  // Saturate a signed 12-bit sum to 0..255, then keep the top 5 bits
  // (plain truncation, no rounding).
  function automatic logic [4:0] clamp_to5(input logic signed [11:0] s);
    logic [7:0] c8;
    if (s[11]) begin
      c8 = 8'd0;
    end else if (s[10:8] != 3'd0) begin
      c8 = 8'd255;
    end else begin
      c8 = s[7:0];
    end
    return 5'(c8 >> 3);
  endfunction

  // Stage state
  logic                     s1_v;
  logic signed [11:0]       s1_r;
  logic signed [11:0]       s1_g;
  logic signed [11:0]       s1_b;
  logic [TAGW-1:0]          s1_tag;
  logic                     s2_v;

  // Handshake
  logic s2_load;
  logic s1_load;
  logic accept;

  assign s2_load = !s2_v || i_ready;
  assign s1_load = !s1_v || s2_load;
  // Clear owns the cycle: nothing is accepted while the stages are flushed.
  assign o_ready = !i_clear && s1_load;
  assign accept  = i_valid && o_ready;
  assign o_valid = s2_v;

  // Stage 1 datapath
  logic [8:0]         m_r;
  logic [8:0]         m_g;
  logic [8:0]         m_b;
  logic signed [11:0] d_off;
  logic signed [11:0] sum_r;
  logic signed [11:0] sum_g;
  logic signed [11:0] sum_b;

  always_comb begin
    m_r   = modulate(i_r, i_texR, i_texEn);
    m_g   = modulate(i_g, i_texG, i_texEn);
    m_b   = modulate(i_b, i_texB, i_texEn);
    d_off = i_ditherEn ? dither_off(i_posY, i_posX) : 12'sd0;
    // m is at most 494 and d is within -4..+3, so 12-bit signed never wraps.
    sum_r = $signed({3'b000, m_r}) + d_off;
    sum_g = $signed({3'b000, m_g}) + d_off;
    sum_b = $signed({3'b000, m_b}) + d_off;
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_v   <= 1'b0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
    end else if (i_clear) begin
      s1_v <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_v <= i_valid;
      end
      if (accept) begin
        s1_r   <= sum_r;
        s1_g   <= sum_g;
        s1_b   <= sum_b;
        s1_tag <= i_tag;
      end
    end
  end

  // Stage 2: saturate and register the outputs. Outputs only change when S2
  // loads a new pixel, so they stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s2_v  <= 1'b0;
      o_r   <= '0;
      o_g   <= '0;
      o_b   <= '0;
      o_tag <= '0;
    end else if (i_clear) begin
      s2_v <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        o_r   <= clamp_to5(s1_r);
        o_g   <= clamp_to5(s1_g);
        o_b   <= clamp_to5(s1_b);
        o_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_gpu_dither_modulate.sv
// Purpose: self-checking bench for gpu_dither_modulate using directed
//          scenarios plus a randomized stream against an arithmetic model.
// Ports: none (top-level bench).
module tb_gpu_dither_modulate;

  logic        clk = 1'b0;
  logic        i_nrst;
  logic        i_clear;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_posX;
  logic [1:0]  i_posY;
  logic [7:0]  i_r, i_g, i_b;
  logic [4:0]  i_texR, i_texG, i_texB;
  logic        i_texEn;
  logic        i_ditherEn;
  logic [15:0] i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_r, o_g, o_b;
  logic [15:0] o_tag;

  gpu_dither_modulate #(.TAGW(16)) dut (
    .clk(clk), .i_nrst(i_nrst), .i_clear(i_clear), .i_valid(i_valid),
    .o_ready(o_ready), .i_posX(i_posX), .i_posY(i_posY),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_texR(i_texR), .i_texG(i_texG), .i_texB(i_texB),
    .i_texEn(i_texEn), .i_ditherEn(i_ditherEn), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [4:0]  g;
    logic [4:0]  b;
    logic [15:0] tag;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          dtab[16];
  int          ecount;
  int          total;
  int          bad;
  int          n_dut;
  bit          last_acc;
  bit          dir_chk;
  logic [4:0]  dir_r, dir_g, dir_b;
  logic [15:0] dir_tag;
  string       dir_name;

  // Spec arithmetic: modulation, dither, saturate to 0..255, keep 5 MSBs.
  function automatic logic [4:0] ref_ch(int col, int tex, bit te, bit de, int x, int y);
    int m;
    int s;
    m = te ? (col * tex) / 16 : col;
    s = m + (de ? dtab[y * 4 + x] : 0);
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 5'(s / 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int r, input int g, input int b, input int tr, input int tg,
                         input int tb, input bit te, input bit de, input int x, input int y,
                         input int tag);
    i_r = 8'(r); i_g = 8'(g); i_b = 8'(b);
    i_texR = 5'(tr); i_texG = 5'(tg); i_texB = 5'(tb);
    i_texEn = te; i_ditherEn = de;
    i_posX = 2'(x); i_posY = 2'(y); i_tag = 16'(tag);
  endtask

  task automatic rand_pix();
    set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 65535));
  endtask

  // One clock cycle: check DUT against the model at the negedge, advance the
  // model by the handshakes that will happen on the coming edge, then return
  // 1 time unit after the posedge so the caller can drive the next inputs.
  task automatic cycle();
    bit   exp_vld;
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    exp_vld = (q.size() > 0) && ((ecount - q[0].acc) >= 2);
    exp_rdy = !i_clear && ((q.size() < 2) || i_ready);
    chk("o_valid", 32'(o_valid), 32'(exp_vld));
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    if (exp_vld) begin
      chk("o_r", 32'(o_r), 32'(q[0].r));
      chk("o_g", 32'(o_g), 32'(q[0].g));
      chk("o_b", 32'(o_b), 32'(q[0].b));
      chk("o_tag", 32'(o_tag), 32'(q[0].tag));
    end
    if (dir_chk) begin
      chk({dir_name, "_vld"}, 32'(o_valid), 32'd1);
      chk({dir_name, "_r"}, 32'(o_r), 32'(dir_r));
      chk({dir_name, "_g"}, 32'(o_g), 32'(dir_g));
      chk({dir_name, "_b"}, 32'(o_b), 32'(dir_b));
      chk({dir_name, "_tag"}, 32'(o_tag), 32'(dir_tag));
      dir_chk = 1'b0;
    end
    last_acc = i_valid && exp_rdy;
    if (o_valid && i_ready && !i_clear) n_dut++;
    if (i_clear) begin
      q.delete();
    end else begin
      if (exp_vld && i_ready) void'(q.pop_front());
      if (last_acc) begin
        e.r   = ref_ch(int'(i_r), int'(i_texR), i_texEn, i_ditherEn, int'(i_posX), int'(i_posY));
        e.g   = ref_ch(int'(i_g), int'(i_texG), i_texEn, i_ditherEn, int'(i_posX), int'(i_posY));
        e.b   = ref_ch(int'(i_b), int'(i_texB), i_texEn, i_ditherEn, int'(i_posX), int'(i_posY));
        e.tag = i_tag;
        e.acc = ecount;
        q.push_back(e);
      end
    end
    @(posedge clk);
    ecount++;
    #1;
  endtask

  task automatic set_dir(input string name, input int r, input int g, input int b, input int tag);
    dir_chk = 1'b1; dir_name = name;
    dir_r = 5'(r); dir_g = 5'(g); dir_b = 5'(b); dir_tag = 16'(tag);
  endtask

  // Directed table for dither/clamp and modulation cases.
  int  t_col[8] = '{0, 255, 6, 255, 128, 128, 255, 40};
  int  t_tex[8] = '{0, 0, 0, 0, 31, 16, 31, 0};
  bit  t_te[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
  bit  t_de[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
  int  t_x[8]   = '{0, 2, 0, 3, 1, 1, 1, 1};
  int  t_y[8]   = '{0, 1, 1, 3, 2, 2, 2, 2};
  int  t_exp[8] = '{0, 31, 1, 31, 31, 16, 31, 0};

  int p;
  int n0;

  initial begin
    dtab = '{-4, 0, -3, 1, 2, -2, 3, -1, -3, 1, -4, 0, 3, -1, 2, -2};
    total = 0; bad = 0; ecount = 0; n_dut = 0; dir_chk = 1'b0; last_acc = 1'b0;
    i_nrst = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    set_pix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_r", 32'(o_r), 32'd0);
    chk("rst_o_g", 32'(o_g), 32'd0);
    chk("rst_o_b", 32'(o_b), 32'd0);
    chk("rst_o_tag", 32'(o_tag), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    i_nrst = 1'b1;
    #1;
    chk("rst_o_ready", 32'(o_ready), 32'd1);

    // 1. Passthrough with exact 2-cycle latency
    set_pix(200, 100, 8, 0, 0, 0, 0, 0, 0, 0, 16'hA5C3);
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    cycle();
    set_dir("pass", 25, 12, 1, 16'hA5C3);
    cycle();

    // 2/3. Dither, clamp and modulation table, streamed back to back
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        set_pix(t_col[i], t_col[i], t_col[i], t_tex[i], t_tex[i], t_tex[i],
                t_te[i], t_de[i], t_x[i], t_y[i], 16'h100 + i);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      if (i >= 2) set_dir($sformatf("tab%0d", i - 2), t_exp[i - 2], t_exp[i - 2],
                          t_exp[i - 2], 16'h100 + i - 2);
      cycle();
    end

    // 4. Backpressure: 5 pixels, consumer stalls for cycles 3..6
    p = 0;
    n0 = n_dut;
    for (int c = 0; c < 14; c++) begin
      i_valid = (p < 5);
      set_pix(30 * p + 7, 255 - 20 * p, 50 + p, 0, 0, 0, 0, 1, p % 4, 1, 16'h40 + p);
      i_ready = !(c >= 3 && c <= 6);
      cycle();
      if (last_acc) p++;
    end
    chk("bp_count", 32'(n_dut - n0), 32'd5);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // 5. Clear with simultaneous valid and ready
    i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_pix();
      i_valid = 1'b1;
      cycle();
    end
    rand_pix();
    i_clear = 1'b1;
    n0 = n_dut;
    cycle();
    i_clear = 1'b0;
    i_valid = 1'b0;
    cycle();
    cycle();
    chk("clr_none_out", 32'(n_dut - n0), 32'd0);
    set_pix(64, 136, 255, 0, 0, 0, 0, 0, 0, 0, 16'h0C1E);
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    cycle();
    set_dir("clr_next", 8, 17, 31, 16'h0C1E);
    cycle();

    // 6. Asynchronous reset mid-stream, off the clock edge
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rand_pix();
      i_valid = 1'b1;
      cycle();
    end
    #3;
    i_nrst = 1'b0;
    #1;
    chk("arst_o_valid", 32'(o_valid), 32'd0);
    chk("arst_o_r", 32'(o_r), 32'd0);
    chk("arst_o_tag", 32'(o_tag), 32'd0);
    q.delete();
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    i_nrst = 1'b1;
    #1;
    chk("arst_rel_ready", 32'(o_ready), 32'd1);
    chk("arst_rel_valid", 32'(o_valid), 32'd0);
    n0 = n_dut;
    cycle();
    cycle();
    cycle();
    chk("arst_no_stale", 32'(n_dut - n0), 32'd0);

    // Randomized stream with random backpressure and occasional clears
    for (int c = 0; c < 600; c++) begin
      rand_pix();
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_clear = ($urandom_range(0, 59) == 0);
      cycle();
    end
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
